audio_interpolator: RTL and testbench
=====================================

# audio_interpolator

Upsamples a stream of signed audio samples by a fixed power-of-two ratio using first-order (linear) interpolation, emitting one output sample per `enable` tick. It is the inverse of the moving-average decimation path. It sits between a slow-rate sample producer and the codec-rate DAC path. Input uses a valid/ready handshake backed by a one-entry holding buffer. Output is a registered sample with a one-cycle `out_valid` strobe.

## Interface
- `AUDIO_DATA_WIDTH`, 24, sample width (signed two's complement)
- `RATIO`, 32, output samples per input sample; must be a power of two
- `N`, 5, log2(`RATIO`)
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  output-rate tick; one output sample per high cycle
- `in_valid`  in  1  `in_sample` is valid
- `in_ready`  out  1  holding buffer empty; transfer occurs when `in_valid && in_ready`
- `in_sample`  in  `AUDIO_DATA_WIDTH`  signed input sample
- `out_valid`  out  1  one-cycle strobe, the cycle after each `enable` tick
- `out_sample`  out  `AUDIO_DATA_WIDTH`  signed interpolated sample
- `underrun`  out  1  one-cycle pulse coincident with `out_valid` when a segment ends with no sample buffered

## Operation
- Registers:
  - `next` (holding buffer) plus `next_full`
  - `cur` (segment target)
  - `acc` (signed, W+N+1 bits)
  - `diff` (signed, W+1 bits) = `cur` − previous `cur`
  - phase counter `k`, 0..RATIO-1
- States:
  - IDLE: no segment has started since reset.
  - RUN: a segment is in progress.
  - HOLD: a segment finished with nothing buffered.
- Accept: when `in_valid && in_ready`, `next <= in_sample` and `next_full <= 1`. `in_ready = !next_full` is derived from registered state only (no combinational path from `in_valid`).
- Segment start, on a tick when in IDLE/HOLD, or when in RUN at `k==RATIO-1`, with `next_full`:
  - `diff <= next - cur`, `cur <= next`, `next_full <= 0`, `k <= 0`
  - go to RUN
- Segment start without `next_full`:
  - `diff <= 0`, go to or stay in HOLD.
  - `underrun` pulses only on the RUN→HOLD transition.
- Per tick: `out_sample <= acc >>> N`, then `acc <= acc + diff` (using the diff in force for that phase). In RUN, `k <= k+1`.
- Phase `j` of a segment from P to C outputs floor((P·(RATIO−j) + C·j)/RATIO).
  - Phase 0 outputs P exactly.
  - After RATIO ticks, `acc == C<<N` exactly, so there is no drift or reload.
- HOLD/IDLE ticks output `acc >>> N` unchanged (last target, or 0 after reset).
- Simultaneous accept and segment boundary in the same cycle: the new sample lands in `next` and is not used by this boundary. Go to HOLD (no bypass).
- No saturation is needed: interpolated values always lie between two valid W-bit samples.

## Timing
- Reset values:
  - `out_sample` 0, `out_valid` 0, `underrun` 0, `in_ready` 1
  - `acc` 0, `cur` 0, `diff` 0, `k` 0, state IDLE
- Assertion of `reset_n` mid-segment aborts immediately and discards `next`.
- Output latency is 1 cycle from the `enable` tick to `out_valid`.
- An accepted sample becomes segment target at the next boundary tick. Its value is reached RATIO ticks later.
- `in_ready` reasserts the cycle after the boundary tick that consumes `next`.
- `enable` may be high on consecutive cycles; each high cycle is a tick.

## Configuration
- `AUDIO_INTERP_LINEAR_EN` defined: linear interpolation as above.
- Not defined: zero-order hold.
  - At segment start, `acc <= next<<N` and `diff <= 0`.
  - Phase 0 outputs the new sample directly; all phases repeat it.
  - Handshake, states and `underrun` are unchanged.

## Structure
- Package `audio_pkg`: default `AUDIO_DATA_WIDTH`, the state enum (IDLE/RUN/HOLD), and a `clog2`-style constant helper for `N`.
- One sub-module, `interp_input_buffer`: the one-entry holding register with valid/ready, `next_full` and a pop strobe.
- Add an elaboration check that `RATIO == 1<<N`.

## Test plan
- RATIO=4, N=2, feed 400 after reset, ticks continuous → outputs 0,100,200,300; after feeding 0 → 400,300,200,100.
- Feed −8 from reset (RATIO=4) → outputs 0,−2,−4,−6, then the held −8 stream.
- Default params, max positive then max negative sample → outputs monotonic, no overflow, reaching −2^23 exactly after 32 ticks.
- Stop feeding mid-stream → exactly one `underrun` pulse at the RUN→HOLD tick; outputs hold the last target; a new sample restarts the ramp from it.
- Hold `in_valid` high with gaps in `enable` → `in_ready` low while full, one accept per segment, no sample lost or duplicated.
- Assert `reset_n` low mid-segment with the buffer full → all outputs 0 and `in_ready`=1 immediately; the first post-reset segment ramps from 0.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg
// Shared definitions for the audio interpolator slice:
//   AUDIO_DATA_WIDTH_DEFAULT - default signed sample width
//   RATIO_DEFAULT            - default upsampling ratio (power of two)
//   interp_state_t           - segment FSM states (IDLE / RUN / HOLD)
//   clog2()                  - constant helper used to derive N from RATIO
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH_DEFAULT = 24;
    localparam int RATIO_DEFAULT            = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } interp_state_t;

    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/audio_interpolator_if.sv
// audio_interpolator_if
// Groups the sample-side handshake and the output strobe of the interpolator.
//   enable     - output-rate tick (producer side drives)
//   in_valid   - in_sample is valid
//   in_ready   - holding buffer empty
//   in_sample  - signed input sample
//   out_valid  - one-cycle strobe the cycle after each tick
//   out_sample - signed interpolated sample
//   underrun   - pulse with out_valid when a segment ends with nothing buffered
// Modports: master = producer/consumer environment, slave = interpolator.
interface audio_interpolator_if #(
    parameter int W = 24
) ();

    logic                enable;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_sample;
    logic                out_valid;
    logic signed [W-1:0] out_sample;
    logic                underrun;

    modport master (
        output enable, in_valid, in_sample,
        input  in_ready, out_valid, out_sample, underrun
    );

    modport slave (
        input  enable, in_valid, in_sample,
        output in_ready, out_valid, out_sample, underrun
    );

endinterface

// File: rtl/interp_input_buffer.sv
// interp_input_buffer
// One-entry holding register in front of the interpolator.
//   clk, rst_n - clock, asynchronous active-low reset
//   i_valid    - producer has a sample
//   i_data     - producer sample
//   i_pop      - interpolator consumes the held sample
//   o_ready    - buffer empty (registered state only)
//   o_full     - buffer holds a sample
//   o_data     - held sample
module interp_input_buffer #(
    parameter int W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    input  logic signed [W-1:0] i_data,
    input  logic                i_pop,
    output logic                o_ready,
    output logic                o_full,
    output logic signed [W-1:0] o_data
);

    logic                r_full;
    logic signed [W-1:0] r_data;

    // Push needs an empty buffer and pop needs a full one, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/audio_interpolator.sv
// audio_interpolator
// Upsamples signed audio by RATIO (power of two), one output per enable tick.
// Build option: AUDIO_INTERP_LINEAR_EN defined -> linear interpolation;
//               undefined -> zero-order hold.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   bus     - audio_interpolator_if.slave (enable, in_valid/in_ready/in_sample,
//             out_valid/out_sample/underrun)
module audio_interpolator
    import audio_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = AUDIO_DATA_WIDTH_DEFAULT,
    parameter int RATIO            = RATIO_DEFAULT,
    parameter int N                = clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    audio_interpolator_if.slave  bus
);

    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int AW = W + N + 1;
    localparam int KW = (N > 0) ? N : 1;
    localparam logic [KW-1:0] K_LAST = KW'(RATIO - 1);

    if (RATIO != (1 << N)) begin : g_ratio_check
        $error("audio_interpolator: RATIO must equal 1<<N");
    end

    interp_state_t       r_state;
    interp_state_t       w_state_nxt;
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_acc_nxt;
    logic [KW-1:0]       r_k;
    logic signed [W-1:0] r_out;
    logic signed [W-1:0] w_out_nxt;
    logic                r_out_valid;
    logic                r_underrun;

    logic                w_full;
    logic signed [W-1:0] w_next;
    logic                w_boundary;
    logic                w_seg_end;
    logic                w_start;
    logic                w_underrun;

`ifdef AUDIO_INTERP_LINEAR_EN
    localparam int DW = W + 1;
    logic signed [W-1:0]  r_cur;
    logic signed [DW-1:0] r_diff;
    logic signed [DW-1:0] w_diff_nxt;
`endif

    interp_input_buffer #(
        .W (W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_valid (bus.in_valid),
        .i_data  (bus.in_sample),
        .i_pop   (w_start),
        .o_ready (bus.in_ready),
        .o_full  (w_full),
        .o_data  (w_next)
    );

    // Segment FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Segment FSM: boundary detection and next state
    always_comb begin
        w_boundary  = (r_state != ST_RUN) || (r_k == K_LAST);
        w_seg_end   = bus.enable && w_boundary;
        w_start     = w_seg_end && w_full;
        w_underrun  = w_seg_end && !w_full && (r_state == ST_RUN);
        w_state_nxt = r_state;
        if (w_seg_end) begin
            w_state_nxt = w_full ? ST_RUN : ST_HOLD;
        end
    end

    // Datapath next values
    always_comb begin
        w_out_nxt = W'(r_acc >>> N);
`ifdef AUDIO_INTERP_LINEAR_EN
        // The new slope applies to the boundary tick itself, so phase 0 emits
        // the old target while acc already steps toward the new one.
        w_diff_nxt = r_diff;
        if (w_seg_end) begin
            w_diff_nxt = w_start ? ($signed({w_next[W-1], w_next}) - $signed({r_cur[W-1], r_cur}))
                                 : '0;
        end
        w_acc_nxt = r_acc + {{(AW-DW){w_diff_nxt[DW-1]}}, w_diff_nxt};
`else
        w_acc_nxt = r_acc;
        if (w_start) begin
            w_acc_nxt = AW'(w_next) <<< N;
            w_out_nxt = w_next;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_k         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_underrun  <= 1'b0;
`ifdef AUDIO_INTERP_LINEAR_EN
            r_cur       <= '0;
            r_diff      <= '0;
`endif
        end else begin
            r_out_valid <= bus.enable;
            r_underrun  <= w_underrun;
            if (bus.enable) begin
                r_out <= w_out_nxt;
                r_acc <= w_acc_nxt;
                r_k   <= w_boundary ? '0 : r_k + KW'(1);
`ifdef AUDIO_INTERP_LINEAR_EN
                r_diff <= w_diff_nxt;
                if (w_start) begin
                    r_cur <= w_next;
                end
`endif
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_sample = r_out;
    assign bus.underrun   = r_underrun;

endmodule

// File: tb/tb_audio_interpolator.sv
// tb_audio_interpolator
// Self-checking bench for audio_interpolator (RATIO=4, N=2, 24-bit samples).
// The reference model follows the segment rules directly: a segment from P to
// C emits floor((P*(R-j)+C*j)/R) at phase j (or C under zero-order hold when
// AUDIO_INTERP_LINEAR_EN is undefined), and holds C between segments.
module tb_audio_interpolator;

    localparam int W = 24;
    localparam int R = 4;

    logic clk;
    logic reset_n;

    audio_interpolator_if #(.W(W)) bus ();

    audio_interpolator #(
        .AUDIO_DATA_WIDTH (W),
        .RATIO            (R),
        .N                (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miss;

    // producer queue and reference model state
    int      q[$];
    longint  m_prev, m_cur, m_next;
    bit      m_full, m_inseg;
    int      m_j;
    longint  m_out;
    bit      m_valid, m_under;

    function automatic longint fdiv(input longint a, input longint b);
        longint qq;
        qq = a / b;
        if ((a % b != 0) && (a < 0)) qq = qq - 1;
        return qq;
    endfunction

    function automatic longint phase_value(input int j);
`ifdef AUDIO_INTERP_LINEAR_EN
        return fdiv(m_prev * (R - j) + m_cur * j, R);
`else
        return m_cur + 0 * j;
`endif
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_cur = 0; m_next = 0;
        m_full = 0; m_inseg = 0; m_j = 0;
        m_out = 0; m_valid = 0; m_under = 0;
    endtask

    task automatic apply_reset();
        bus.enable    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        reset_n = 1'b0;
        #1;
        model_reset();
        q.delete();
        check("rst_out_sample", bus.out_sample, 0);
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_underrun",   bus.underrun,   0);
        check("rst_in_ready",   bus.in_ready,   1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock: drive inputs, advance the model on the edge, check #1 later.
    task automatic step(input bit en, input bit vgate);
        bit     accept;
        longint sample;
        bus.enable    = en;
        bus.in_valid  = vgate && (q.size() > 0);
        sample        = (q.size() > 0) ? longint'(q[0]) : 0;
        bus.in_sample = W'(sample);
        @(posedge clk);
        accept  = bus.in_valid && !m_full;
        m_valid = en;
        m_under = 0;
        if (en) begin
            if (m_inseg && m_j < R) begin
                m_out = phase_value(m_j);
                m_j++;
            end else if (m_full) begin
                m_prev = m_cur;
                m_cur  = m_next;
                m_full = 0;
                m_inseg = 1;
                m_out  = phase_value(0);
                m_j    = 1;
            end else begin
                if (m_inseg) m_under = 1;
                m_inseg = 0;
                m_out = m_cur;
            end
        end
        if (accept) begin
            m_next = sample;
            m_full = 1;
            void'(q.pop_front());
        end
        #1;
        check("out_valid",  bus.out_valid,  m_valid);
        check("underrun",   bus.underrun,   m_under);
        check("in_ready",   bus.in_ready,   !m_full);
        check("out_sample", bus.out_sample, m_out);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset_n = 1'b0;
        bus.enable = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sample = '0;
        #3;
        apply_reset();

        // ramp up to 400 then back down to 0, then underrun and hold
        q.push_back(400);
        q.push_back(0);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1);

        // new sample after hold restarts the ramp from the held target
        q.push_back(-1000);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);

        // negative ramp from reset
        apply_reset();
        q.push_back(-8);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

        // full-scale swing
        apply_reset();
        q.push_back(8388607);
        q.push_back(-8388608);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
        check("fullscale_end", bus.out_sample, -8388608);

        // randomized enable gaps and producer stalls
        apply_reset();
        for (int i = 0; i < 40; i++) q.push_back(int'($signed(W'($urandom))));
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 200 && (q.size() > 0 || m_full || m_inseg); i++)
            step(1'b1, 1'b1);
        check("random_drained", q.size(), 0);

        // reset mid-segment with the buffer full
        apply_reset();
        q.push_back(500);
        q.push_back(600);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        check("pre_reset_full", bus.in_ready, 0);
        apply_reset();
        q.push_back(1000);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
